// File: rtl/apu_frame_counter_pkg.sv
// apu_pkg: frame sequencer step constants and mode type shared by the frame counter and its users
package apu_pkg;
    localparam int Q1_STEP_DEF    = 7457;
    localparam int Q2_STEP_DEF    = 14913;
    localparam int Q3_STEP_DEF    = 22371;
    localparam int Q4_STEP_M0_DEF = 29829;
    localparam int Q4_STEP_M1_DEF = 37281;
    localparam int PERIOD_M0      = Q4_STEP_M0_DEF + 1;
    localparam int PERIOD_M1      = Q4_STEP_M1_DEF + 1;
    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } frame_mode_t;
endpackage

// File: rtl/apu_frame_counter_if.sv
// apu_frame_counter_if: CPU-side register strobes and frame sequencer outputs
interface apu_frame_counter_if;
    logic       cpu_en;
    logic       wr_4017;
    logic [1:0] wr_data;
    logic       rd_4015;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;
    logic       mode;
    modport master (output cpu_en, wr_4017, wr_data, rd_4015, input quarter_frame, half_frame, frame_irq, mode);
    modport slave  (input cpu_en, wr_4017, wr_data, rd_4015, output quarter_frame, half_frame, frame_irq, mode);
endinterface

// File: rtl/apu_frame_counter.sv
// apu_frame_counter: $4017 frame sequencer emitting quarter/half-frame strobes and the frame IRQ flag
module apu_frame_counter
    import apu_pkg::*;
#(
    parameter int Q1_STEP    = Q1_STEP_DEF,
    parameter int Q2_STEP    = Q2_STEP_DEF,
    parameter int Q3_STEP    = Q3_STEP_DEF,
    parameter int Q4_STEP_M0 = Q4_STEP_M0_DEF,
    parameter int Q4_STEP_M1 = Q4_STEP_M1_DEF
) (
    input logic                clk,
    input logic                reset,
    apu_frame_counter_if.slave bus_io
);
    localparam logic [15:0] S1     = 16'(Q1_STEP);
    localparam logic [15:0] S2     = 16'(Q2_STEP);
    localparam logic [15:0] S3     = 16'(Q3_STEP);
    localparam logic [15:0] S4_M0  = 16'(Q4_STEP_M0);
    localparam logic [15:0] S4_M1  = 16'(Q4_STEP_M1);
    localparam logic [15:0] S4_PRE = 16'(Q4_STEP_M0 - 1);
    logic [15:0] count_q, count_d;
    logic [2:0]  delay_q, delay_d;
    frame_mode_t mode_q, mode_d, pend_q, pend_d;
    logic inhibit_q, inhibit_d, irq_q, irq_d, tail_q, tail_d;
    logic quarter_q, quarter_d, half_q, half_d, phase_q;
    logic wr, expire, last, irq_set;
    always_comb begin
        wr        = bus_io.wr_4017;
        expire    = delay_q == 3'd1 && !wr;
        last      = count_q == (mode_q == MODE_5STEP ? S4_M1 : S4_M0);
        inhibit_d = wr ? bus_io.wr_data[0] : inhibit_q;
        irq_set   = mode_q == MODE_4STEP && !inhibit_d && (count_q == S4_PRE || count_q == S4_M0 || tail_q);
        irq_d     = irq_set || (irq_q && !bus_io.rd_4015 && !inhibit_d);
        tail_d    = mode_q == MODE_4STEP && last && !expire;
        count_d   = (expire || last) ? 16'd0 : count_q + 16'd1;
        mode_d    = expire ? pend_q : mode_q;
        pend_d    = wr ? frame_mode_t'(bus_io.wr_data[1]) : pend_q;
        // write loads the restart delay; otherwise it runs down to zero and holds
        delay_d   = wr ? (phase_q ? 3'd4 : 3'd3) : delay_q - 3'(delay_q != 3'd0);
        quarter_d = expire ? (pend_q == MODE_5STEP) : (count_q == S1 || count_q == S2 || count_q == S3 || last);
        half_d    = expire ? (pend_q == MODE_5STEP) : (count_q == S2 || last);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            delay_q   <= '0;
            mode_q    <= MODE_4STEP;
            pend_q    <= MODE_4STEP;
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
            tail_q    <= 1'b0;
            quarter_q <= 1'b0;
            half_q    <= 1'b0;
            phase_q   <= 1'b0;
        end else if (bus_io.cpu_en) begin
            count_q   <= count_d;
            delay_q   <= delay_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            inhibit_q <= inhibit_d;
            irq_q     <= irq_d;
            tail_q    <= tail_d;
            quarter_q <= quarter_d;
            half_q    <= half_d;
            phase_q   <= !phase_q;
        end
    end
    assign bus_io.quarter_frame = quarter_q;
    assign bus_io.half_frame    = half_q;
    assign bus_io.frame_irq     = irq_q;
    assign bus_io.mode          = mode_q;
endmodule

// File: doc/apu_frame_counter.md
Name: apu_frame_counter

Overview:
APU frame sequencer behind register $4017. Counts CPU cycles and emits one-cpu_en-period quarter_frame and half_frame strobes to the length counters, envelopes, sweeps and linear counter. Implements 4-step and 5-step modes, the delayed sequencer restart after a $4017 write, and the frame IRQ flag read and cleared through $4015.

Parameters:
Q1_STEP, 7457, CPU-cycle count of the first quarter-frame strobe.
Q2_STEP, 14913, count of the second quarter strobe and the first half strobe.
Q3_STEP, 22371, count of the third quarter strobe.
Q4_STEP_M0, 29829, final step in mode 0 (quarter + half); period is Q4_STEP_M0+1.
Q4_STEP_M1, 37281, final step in mode 1 (quarter + half); period is Q4_STEP_M1+1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
cpu_en  in  1  CPU-cycle enable; all state advances only when it is high (except reset)
wr_4017  in  1  CPU write to $4017, qualified with cpu_en
wr_data  in  2  write data bits [7:6]: [1]=mode (0 = 4-step, 1 = 5-step), [0]=irq_inhibit
rd_4015  in  1  CPU read of $4015, qualified with cpu_en; clears frame IRQ flag
quarter_frame  out  1  strobe, high for exactly one cpu_en period
half_frame  out  1  strobe, high for exactly one cpu_en period
frame_irq  out  1  frame interrupt flag (level), to CPU IRQ OR and to $4015 bit 6
mode  out  1  current sequencer mode, for debug/status

Behaviour:
- Reset: count=0, mode=0, irq_inhibit=0, frame_irq=0, quarter_frame=0, half_frame=0, phase=0, no write pending.
- Registers update only on cycles with cpu_en=1. Strobes are registered; they are asserted from one cpu_en cycle to the next, so a consumer sampling on cpu_en sees exactly one pulse.
- count is 16 bits, increments by 1 per cpu_en.
  - mode 0: wraps to 0 after Q4_STEP_M0.
  - mode 1: wraps to 0 after Q4_STEP_M1.
- Strobe schedule: strobes are driven on the cpu_en cycle after count equals the step value.
  - count==Q1_STEP or Q3_STEP: quarter only.
  - count==Q2_STEP: quarter and half.
  - mode 0, count==Q4_STEP_M0: quarter and half.
  - mode 1, count==Q4_STEP_M1: quarter and half.
- IRQ, mode 0 only, with irq_inhibit=0: frame_irq is set when count is Q4_STEP_M0-1 or Q4_STEP_M0, and on the first cycle after the wrap (count==0, tracked by a 1-bit irq_tail register). Mode 1 never sets frame_irq.
- frame_irq clear: cleared by rd_4015, or by a write with irq_inhibit=1. If a set and a rd_4015 clear occur in the same cycle, set wins.
- phase: 1-bit register, toggles every cpu_en cycle.
- $4017 write:
  - irq_inhibit is latched immediately. If it is 1, frame_irq clears on the same cycle.
  - mode is held in a pending register.
  - A delay counter loads 3 if phase==0 at the write, otherwise 4.
- Delay expiry (delay counter reaches 0, counting cpu_en cycles after the write cycle):
  - count<=0 and mode<=pending mode.
  - If the new mode is 1, quarter_frame and half_frame are strobed immediately.
  - A strobe scheduled on the same cycle is suppressed, so at most one pulse is produced.
- A second write while a delay is pending restarts the delay and overwrites the pending data.
- A reset while a delay is pending cancels it.
- The count never exceeds the mode period. If a mode change is applied when count > Q4_STEP_M0, the count is restarted to 0 anyway, so no out-of-range count exists.

Decomposition:
- Package apu_pkg holds the step constants (Q1..Q4 values, period values) and the typedef frame_mode_t (MODE_4STEP, MODE_5STEP). Parameters default from these constants.
- Single module. The write-delay logic is about 15 lines and stays inline; no sub-module.

Test Plan:
1. Reset, then run 29830 cpu_en cycles in mode 0. Quarter strobes appear after counts 7457/14913/22371/29829; half strobes after 14913/29829. frame_irq rises at count 29828 and count wraps to 0 after 29829.
2. Write $4017 = 0x80 (mode 1) with phase==0. The sequencer restarts 3 cpu_en cycles later with quarter and half strobed together on that cycle. The next strobes come after counts 7457…37281, and frame_irq stays 0 throughout.
3. Same write with phase==1. The restart and strobes occur 4 cycles after the write, one cycle later than in scenario 2.
4. frame_irq=1, then pulse rd_4015 → frame_irq=0 next cycle. rd_4015 on the cycle count==Q4_STEP_M0 → frame_irq remains 1 (set wins).
5. Write 0x40 while frame_irq=1 → frame_irq=0 next cycle. A full mode-0 period afterwards yields no IRQ, while strobes are unchanged.
6. Write 0x80, then assert reset 2 cycles later. No mode-1 strobe burst occurs; mode=0, count=0, and the first quarter strobe comes after count 7457.
